lift_motion_ctrl: RTL and testbench

- Controller-side counterpart of the lift movement model. It accepts floor requests over a valid/ready handshake and drives `direction`/`motion` toward the target floor.
- It tracks the lift position from the one-hot `floor_sense` contacts and stops on target contact. It then holds the door open for a fixed time.
- It enforces movement safety: direction is never changed while moving, overshoot and multi-hot sense are detected, and a no-progress watchdog runs during motion.

---
 rtl/lift_motion_ctrl_if.sv | 13 +
 rtl/lift_motion_ctrl.sv | 175 +++++++++++++++++
 tb/tb_lift_motion_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lift_motion_ctrl_if.sv
// Floor-request channel between a requester (master) and the lift controller (slave).
// A request transfers on any posedge where req_valid && req_ready; req_err flags an out-of-range transfer one cycle later.
interface lift_motion_ctrl_if #(
    parameter int FW = 4
);
    logic          req_valid;
    logic [FW-1:0] req_floor;
    logic          req_ready;
    logic          req_err;

    modport master (output req_valid, output req_floor, input req_ready, input req_err);
    modport slave  (input req_valid, input req_floor, output req_ready, output req_err);
endinterface

// File: rtl/lift_motion_ctrl.sv
// Lift motion controller: accepts floor requests, drives direction/motion toward the target,
// tracks position from floor contacts, holds the door open per stop and latches movement faults.
module lift_motion_ctrl #(
    parameter int N_FLOORS       = 12,
    parameter int DOOR_OPEN_CLKS = 100,
    parameter int MOVE_TIMEOUT   = 1000,
    parameter int FW             = $clog2(N_FLOORS)
) (
    input  logic                clk,
    input  logic                rst,
    lift_motion_ctrl_if.slave   req,
    input  logic [N_FLOORS-1:0] floor_sense,
    output logic                direction,
    output logic                motion,
    output logic                door_open,
    output logic [FW-1:0]       cur_floor,
    output logic                fault,
    output logic [1:0]          dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MOVING = 2'd1,
        S_DOOR   = 2'd2,
        S_FAULT  = 2'd3
    } state_t;

    localparam int WDW = $clog2(MOVE_TIMEOUT + 1);
    localparam int DTW = $clog2(DOOR_OPEN_CLKS + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(MOVE_TIMEOUT - 1);
    localparam logic [DTW-1:0] DT_LAST = DTW'(DOOR_OPEN_CLKS - 1);

    state_t         r_state, w_state_n;
    logic [FW-1:0]  r_cur_floor;
    logic [FW-1:0]  r_target, w_target_n;
    logic           r_dir, w_dir_n;
    logic           r_motion, w_motion_n;
    logic           r_door, w_door_n;
    logic           r_err, w_err_n;
    logic           r_fault, w_fault_n;
    logic [WDW-1:0] r_wd, w_wd_n;
    logic [DTW-1:0] r_dt, w_dt_n;

    logic           w_onehot;
    logic           w_multi;
    logic [FW-1:0]  w_idx;
    logic           w_req_oor;
    logic           w_arrive;
    logic           w_overshoot;
    logic           w_progress;

    assign w_onehot = $onehot(floor_sense);
    assign w_multi  = !$onehot0(floor_sense);

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (floor_sense[i]) w_idx = FW'(i);
        end
    end

    assign w_req_oor   = (32'(req.req_floor) >= N_FLOORS);
    assign w_arrive    = w_onehot && (w_idx == r_target);
    assign w_overshoot = w_onehot && (r_dir ? (w_idx > r_target) : (w_idx < r_target));
    // Progress means contacting a floor other than the one recorded at the previous contact.
    assign w_progress  = w_onehot && (w_idx != r_cur_floor);

    always_comb begin
        w_state_n  = r_state;
        w_target_n = r_target;
        w_dir_n    = r_dir;
        w_motion_n = r_motion;
        w_door_n   = r_door;
        w_err_n    = 1'b0;
        w_fault_n  = r_fault;
        w_wd_n     = r_wd;
        w_dt_n     = r_dt;
        case (r_state)
            S_IDLE: begin
                if (req.req_valid) begin
                    if (w_req_oor) begin
                        w_err_n = 1'b1;
                    end else if (req.req_floor == r_cur_floor) begin
                        w_state_n = S_DOOR;
                        w_door_n  = 1'b1;
                        w_dt_n    = '0;
                    end else begin
                        w_state_n  = S_MOVING;
                        w_target_n = req.req_floor;
                        w_dir_n    = (req.req_floor > r_cur_floor);
                        w_motion_n = 1'b1;
                        w_wd_n     = '0;
                    end
                end
            end
            S_MOVING: begin
                // Arrival wins over a watchdog expiry on the same cycle.
                if (w_arrive) begin
                    w_state_n  = S_DOOR;
                    w_motion_n = 1'b0;
                    w_door_n   = 1'b1;
                    w_dt_n     = '0;
                end else if (w_overshoot) begin
                    w_state_n = S_FAULT;
                end else if (w_progress) begin
                    w_wd_n = '0;
                end else if (r_wd == WD_LAST) begin
                    w_state_n = S_FAULT;
                end else begin
                    w_wd_n = r_wd + WDW'(1);
                end
            end
            S_DOOR: begin
                if (r_dt == DT_LAST) begin
                    w_state_n = S_IDLE;
                    w_door_n  = 1'b0;
                    w_dt_n    = '0;
                end else begin
                    w_dt_n = r_dt + DTW'(1);
                end
            end
            default: begin
            end
        endcase

        if (w_multi) w_state_n = S_FAULT;
        if (w_state_n == S_FAULT) begin
            w_motion_n = 1'b0;
            w_door_n   = 1'b0;
            w_fault_n  = 1'b1;
            w_err_n    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_target <= '0;
            r_dir    <= 1'b1;
            r_motion <= 1'b0;
            r_door   <= 1'b0;
            r_err    <= 1'b0;
            r_fault  <= 1'b0;
            r_wd     <= '0;
            r_dt     <= '0;
        end else begin
            r_state  <= w_state_n;
            r_target <= w_target_n;
            r_dir    <= w_dir_n;
            r_motion <= w_motion_n;
            r_door   <= w_door_n;
            r_err    <= w_err_n;
            r_fault  <= w_fault_n;
            r_wd     <= w_wd_n;
            r_dt     <= w_dt_n;
        end
    end

    // Position is frozen once faulted so the last trusted floor stays visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur_floor <= '0;
        end else if (r_state != S_FAULT && w_onehot) begin
            r_cur_floor <= w_idx;
        end
    end

    assign req.req_ready = (r_state == S_IDLE);
    assign req.req_err   = r_err;
    assign direction     = r_dir;
    assign motion        = r_motion;
    assign door_open     = r_door;
    assign cur_floor     = r_cur_floor;
    assign fault         = r_fault;
    assign dbg_state     = r_state;
endmodule

// File: tb/tb_lift_motion_ctrl.sv
// Bench for lift_motion_ctrl: a paired lift plant drives floor_sense from the commanded motion,
// a behavioural model predicts every output each cycle, and directed cases pin literal values.
module tb_lift_motion_ctrl;
    localparam int N_FLOORS       = 12;
    localparam int DOOR_OPEN_CLKS = 100;
    localparam int MOVE_TIMEOUT   = 1000;
    localparam int FW             = 4;
    localparam int R              = 3;
    localparam int PH_IDLE  = 0;
    localparam int PH_MOVE  = 1;
    localparam int PH_DOOR  = 2;
    localparam int PH_FAULT = 3;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [N_FLOORS-1:0] floor_sense;
    logic                direction, motion, door_open, fault;
    logic [FW-1:0]       cur_floor;
    logic [1:0]          dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    lift_motion_ctrl_if #(.FW(FW)) io ();

    lift_motion_ctrl #(
        .N_FLOORS(N_FLOORS), .DOOR_OPEN_CLKS(DOOR_OPEN_CLKS),
        .MOVE_TIMEOUT(MOVE_TIMEOUT), .FW(FW)
    ) dut (
        .clk(clk), .rst(rst), .req(io), .floor_sense(floor_sense),
        .direction(direction), .motion(motion), .door_open(door_open),
        .cur_floor(cur_floor), .fault(fault), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Lift plant: position in ticks, T ticks per floor, contact within +-R ticks of a floor.
    int                  p_pos = 0;
    int                  p_T = 200;
    int                  p_home = 0;
    bit                  p_tele = 1'b1;
    bit                  p_force_en = 1'b0;
    logic [N_FLOORS-1:0] p_force_val = '0;

    function automatic logic [N_FLOORS-1:0] sense_of(input int pos, input int t);
        logic [N_FLOORS-1:0] s;
        int k;
        int d;
        s = '0;
        k = (pos + t / 2) / t;
        d = pos - k * t;
        if (d >= -R && d <= R && k >= 0 && k < N_FLOORS) s[k] = 1'b1;
        return s;
    endfunction

    assign floor_sense = p_force_en ? p_force_val : sense_of(p_pos, p_T);

    always @(negedge clk) begin
        if (rst) begin
            if (p_tele) p_pos = p_home;
        end else if (motion) begin
            p_pos = direction ? p_pos + 1 : p_pos - 1;
            if (p_pos < 0) p_pos = 0;
            if (p_pos > (N_FLOORS - 1) * p_T) p_pos = (N_FLOORS - 1) * p_T;
        end
    end

    // Behavioural model of the controller.
    int m_phase = PH_IDLE;
    int m_floor = 0;
    int m_target = 0;
    int m_wait = 0;
    int m_door_left = 0;
    bit m_dir = 1'b1, m_motion = 1'b0, m_door = 1'b0, m_err = 1'b0, m_fault = 1'b0;
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        int hot;
        int idx;
        int prev;
        bit go_fault;
        if (rst) begin
            m_phase = PH_IDLE; m_floor = 0; m_target = 0; m_wait = 0; m_door_left = 0;
            m_dir = 1'b1; m_motion = 1'b0; m_door = 1'b0; m_err = 1'b0; m_fault = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            hot = $countones(floor_sense);
            idx = (hot == 1) ? $clog2(floor_sense) : -1;
            prev = m_floor;
            go_fault = 1'b0;
            m_err = 1'b0;
            if (m_phase != PH_FAULT && hot == 1) m_floor = idx;
            if (hot > 1) begin
                go_fault = 1'b1;
            end else begin
                case (m_phase)
                    PH_IDLE: if (io.req_valid) begin
                        if (int'(io.req_floor) >= N_FLOORS) begin
                            m_err = 1'b1;
                        end else if (int'(io.req_floor) == prev) begin
                            m_phase = PH_DOOR; m_door = 1'b1; m_door_left = DOOR_OPEN_CLKS;
                        end else begin
                            m_target = int'(io.req_floor);
                            m_dir = (m_target > prev);
                            m_motion = 1'b1; m_wait = 0; m_phase = PH_MOVE;
                        end
                    end
                    PH_MOVE: begin
                        if (idx == m_target) begin
                            m_motion = 1'b0; m_door = 1'b1; m_door_left = DOOR_OPEN_CLKS;
                            m_phase = PH_DOOR;
                        end else if (idx >= 0 && (m_dir ? idx > m_target : idx < m_target)) begin
                            go_fault = 1'b1;
                        end else if (idx >= 0 && idx != prev) begin
                            m_wait = 0;
                        end else begin
                            m_wait++;
                            if (m_wait >= MOVE_TIMEOUT) go_fault = 1'b1;
                        end
                    end
                    PH_DOOR: begin
                        m_door_left--;
                        if (m_door_left == 0) begin
                            m_door = 1'b0; m_phase = PH_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
            if (go_fault) begin
                m_phase = PH_FAULT; m_motion = 1'b0; m_door = 1'b0; m_fault = 1'b1; m_err = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Every cycle: compare all outputs against the model, then let inputs change away from posedge.
    task automatic step();
        logic [9:0] act;
        logic [9:0] exp;
        @(negedge clk);
        if (m_valid) begin
            act = {io.req_ready, io.req_err, fault, motion, direction, door_open, cur_floor};
            exp = {m_phase == PH_IDLE, m_err, m_fault, m_motion, m_dir, m_door, FW'(m_floor)};
            check("cycle_model", act, exp);
        end
        #1;
    endtask

    task automatic do_reset(input int t, input int home);
        p_T = t; p_home = home; p_tele = 1'b1;
        rst = 1'b1;
        repeat (3) step();
        check("reset_vals", {motion, direction, door_open, fault, io.req_ready, io.req_err, cur_floor},
              {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0});
        rst = 1'b0;
        step();
        p_tele = 1'b0;
    endtask

    task automatic send_req(input int f);
        io.req_valid = 1'b1;
        io.req_floor = FW'(f);
        step();
        io.req_valid = 1'b0;
    endtask

    task automatic wait_sense(input logic [N_FLOORS-1:0] val, input int budget, output int n);
        n = 0;
        while (floor_sense != val && n < budget) begin
            step(); n++;
        end
        check("wait_sense", floor_sense == val, 1);
    endtask

    task automatic wait_between(input int fl, input int budget);
        int n = 0;
        while (!(int'(cur_floor) == fl && floor_sense == '0) && n < budget) begin
            step(); n++;
        end
        check("wait_between", int'(cur_floor) == fl && floor_sense == '0, 1);
    endtask

    task automatic count_door(output int n, output int rdy);
        n = 0; rdy = 0;
        while (door_open && n < 500) begin
            n++;
            if (io.req_ready) rdy++;
            step();
        end
    endtask

    initial begin
        int n;
        int rdy;
        int bad;
        io.req_valid = 1'b0;
        io.req_floor = '0;

        // 1: ground to floor 3, slow plant.
        do_reset(200, 0);
        send_req(3);
        check("t1_start", {direction, motion}, 2'b11);
        wait_sense(12'h008, 1000, n);
        check("t1_travel", (n >= 590 && n <= 600), 1);
        step();
        check("t1_stop", {motion, cur_floor}, {1'b0, 4'd3});
        count_door(n, rdy);
        check("t1_door_len", n, DOOR_OPEN_CLKS);
        check("t1_ready_after", io.req_ready, 1);

        // 2: floor 3 back to ground, direction frozen low.
        send_req(0);
        check("t2_start", {direction, motion}, 2'b01);
        n = 0; bad = 0;
        while (floor_sense != 12'h001 && n < 1000) begin
            step(); n++;
            if (direction !== 1'b0) bad++;
        end
        check("t2_found", floor_sense == 12'h001, 1);
        check("t2_dir_held", bad, 0);
        step();
        check("t2_stop", {motion, direction, cur_floor}, {1'b0, 1'b0, 4'd0});
        count_door(n, rdy);
        check("t2_door_len", n, DOOR_OPEN_CLKS);

        // 3: request the floor the lift is already on.
        do_reset(40, 5 * 40);
        check("t3_floor", cur_floor, 5);
        send_req(5);
        check("t3_door_start", {motion, door_open, io.req_ready}, 3'b010);
        count_door(n, rdy);
        check("t3_door_len", n, DOOR_OPEN_CLKS);
        check("t3_not_ready", rdy, 0);
        check("t3_ready_after", io.req_ready, 1);

        // 4: out-of-range request.
        send_req(12);
        check("t4_err", {io.req_err, io.req_ready, motion, cur_floor}, {1'b1, 1'b1, 1'b0, 4'd5});
        step();
        check("t4_err_clear", {io.req_err, io.req_ready}, 2'b01);

        // 5: reset while between floors 2 and 1 going down.
        send_req(0);
        wait_between(2, 1000);
        rst = 1'b1;
        step();
        check("t5_rst", {motion, direction, cur_floor, fault, io.req_ready},
              {1'b0, 1'b1, 4'd0, 1'b0, 1'b1});
        rst = 1'b0;
        step();
        check("t5_no_resume", motion, 0);

        // 6a: multi-hot contacts while moving.
        send_req(3);
        check("t6_move", motion, 1);
        repeat (10) step();
        p_force_val = 12'h005; p_force_en = 1'b1;
        step();
        p_force_en = 1'b0;
        check("t6_multi", {fault, motion, io.req_ready}, 3'b100);
        repeat (50) step();
        check("t6_sticky", {fault, motion, io.req_ready, door_open}, 4'b1000);

        // 6b: no contacts at all while moving.
        do_reset(40, 0);
        send_req(4);
        p_force_val = '0; p_force_en = 1'b1;
        n = 0;
        while (!fault && n < 1200) begin
            step(); n++;
        end
        p_force_en = 1'b0;
        check("t6_watchdog", n, MOVE_TIMEOUT);
        check("t6_wd_state", {fault, motion}, 2'b10);

        // 6c: contact beyond the target in the travel direction.
        do_reset(40, 0);
        send_req(2);
        wait_between(1, 500);
        p_force_val = 12'h008; p_force_en = 1'b1;
        step();
        p_force_en = 1'b0;
        check("t6_overshoot", {fault, motion}, 2'b10);

        // Random traffic against the model.
        do_reset(24, 24 * $urandom_range(0, N_FLOORS - 1));
        for (int i = 0; i < 6000; i++) begin
            io.req_valid = ($urandom_range(0, 5) == 0);
            io.req_floor = FW'($urandom_range(0, 15));
            step();
        end
        io.req_valid = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
